regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file (write on negedge, read on posedge).
- Shares that port between two requesters:
  - A: in-order ALU writeback, which has priority.
  - B: late load writeback, buffered in a small FIFO.
- Drives wen/addrW/dataW from registers.
- Exports a pending-register mask so decode can stall on registers with a queued load result.

---
 rtl/regfile_wb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for a 32x32 register file.
// Requester A (in-order ALU writeback) always wins the port; requester B
// (late load writeback) is queued in a small FIFO and drains in the gaps.
// An A write to a register kills any queued load to that same register so a
// stale load can never overwrite newer ALU data. pend_mask lets decode stall
// on registers whose load result is still queued.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  input  logic [4:0]      a_addr,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            wen,
  output logic [4:0]      addrW,
  output logic [XLEN-1:0] dataW,
  output logic            stall_a,
  output logic [31:0]     pend_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // FIFO payload storage (no reset needed: only read while the slot is live)
  logic [4:0]      fifo_addr_reg [DEPTH];
  logic [XLEN-1:0] fifo_data_reg [DEPTH];

  // FIFO control state
  logic [DEPTH-1:0] fifo_valid_reg;
  logic [DEPTH-1:0] fifo_kill_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Starvation tracking
  logic [SW-1:0]    starve_reg;
  logic [SW-1:0]    starve_next;
  logic             stall_reg;

  // Registered write port
  logic             wen_reg;
  logic [4:0]       addr_w_reg;
  logic [XLEN-1:0]  data_w_reg;

  // Decoded per-cycle events
  logic             full;
  logic             empty;
  logic             push;
  logic             a_win;
  logic             pop;
  logic [4:0]       head_addr;
  logic [XLEN-1:0]  head_data;
  logic             head_kill;
  logic             push_kill;
  logic [DEPTH-1:0] a_hit;
  logic [31:0]      pend_bits;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign b_ready   = !full;
  assign push      = b_valid && !full;
  // A write to x0 is architecturally a no-op and leaves the port free.
  assign a_win     = a_valid && (a_addr != 5'd0);
  assign pop       = !a_win && !empty;
  assign head_addr = fifo_addr_reg[rd_ptr_reg];
  assign head_data = fifo_data_reg[rd_ptr_reg];
  assign head_kill = fifo_kill_reg[rd_ptr_reg];
  // The entry being enqueued counts as older than a simultaneous A write.
  assign push_kill = (b_addr == 5'd0) || (a_win && (b_addr == a_addr));

  // Per-slot match against the register A is writing this cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign a_hit[gi] = a_win && (fifo_addr_reg[gi] == a_addr);
  end

  // Store the payload of an accepted load into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_reg[wr_ptr_reg] <= b_addr;
      fifo_data_reg[wr_ptr_reg] <= b_data;
    end
  end

  // Track slot validity and kill flags; push and pop never target the same slot
  // because a full FIFO refuses pushes and an empty FIFO never pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_valid_reg <= '0;
      fifo_kill_reg  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_reg == AW'(i))) begin
          fifo_valid_reg[i] <= 1'b1;
          fifo_kill_reg[i]  <= push_kill;
        end else begin
          if (pop && (rd_ptr_reg == AW'(i))) begin
            fifo_valid_reg[i] <= 1'b0;
          end
          if (a_hit[i]) begin
            fifo_kill_reg[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Advance FIFO pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Count cycles the FIFO head is left waiting, saturating at the limit.
  always_comb begin
    starve_next = starve_reg;
    if (empty || pop) begin
      starve_next = '0;
    end else if (starve_reg != SW'(STARVE_LIMIT)) begin
      starve_next = starve_reg + SW'(1);
    end
  end

  // Register the counter and derive stall_a from the value being loaded so the
  // stall drops on the same edge as the pop that relieves the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= '0;
      stall_reg  <= 1'b0;
    end else begin
      starve_reg <= starve_next;
      stall_reg  <= (starve_next == SW'(STARVE_LIMIT));
    end
  end

  // Drive the register-file write port: A first, then the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_reg    <= 1'b0;
      addr_w_reg <= '0;
      data_w_reg <= '0;
    end else if (a_win) begin
      wen_reg    <= 1'b1;
      addr_w_reg <= a_addr;
      data_w_reg <= a_data;
    end else if (pop) begin
      wen_reg <= !head_kill;
      if (!head_kill) begin
        addr_w_reg <= head_addr;
        data_w_reg <= head_data;
      end
    end else begin
      wen_reg <= 1'b0;
    end
  end

  // Collect destinations of live, non-killed entries.
  always_comb begin
    pend_bits = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid_reg[i] && !fifo_kill_reg[i]) begin
        pend_bits[fifo_addr_reg[i]] = 1'b1;
      end
    end
  end

  assign pend_mask = {pend_bits[31:1], 1'b0};
  assign wen       = wen_reg;
  assign addrW     = addr_w_reg;
  assign dataW     = data_w_reg;
  assign stall_a   = stall_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a directed vector table, directed
// multi-cycle sequences and random traffic, all checked against a queue model.
module tb_regfile_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic            clk;
  logic            rst_n;
  logic            a_valid;
  logic [4:0]      a_addr;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_addr;
  logic [XLEN-1:0] b_data;
  logic            wen;
  logic [4:0]      addrW;
  logic [XLEN-1:0] dataW;
  logic            stall_a;
  logic [31:0]     pend_mask;

  regfile_wb_arbiter #(
    .XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wen(wen), .addrW(addrW), .dataW(dataW),
    .stall_a(stall_a), .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  ent_t        q[$];
  int          m_wait;
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_wait = 0;
    m_wen  = 0;
    m_addr = '0;
    m_data = '0;
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] p = '0;
    foreach (q[i]) if (!q[i].kill) p |= (32'd1 << q[i].addr);
    return p;
  endfunction

  // One clock edge of the specification's rules applied to the current inputs.
  function automatic void model_edge();
    int had = q.size();
    bit a_ok = a_valid && (a_addr != 0);
    bit popped = 0;
    if (b_valid && q.size() < DEPTH) q.push_back('{b_addr, b_data, b_addr == 0});
    if (a_ok) begin
      foreach (q[i]) if (q[i].addr == a_addr) q[i].kill = 1;
      m_wen = 1; m_addr = a_addr; m_data = a_data;
    end else if (had > 0) begin
      ent_t h = q.pop_front();
      popped = 1;
      m_wen = !h.kill;
      if (!h.kill) begin m_addr = h.addr; m_data = h.data; end
    end else begin
      m_wen = 0;
    end
    if (had == 0 || popped) m_wait = 0;
    else if (m_wait < LIMIT) m_wait++;
  endfunction

  function automatic void compare_model();
    chk("wen", 64'(wen), 64'(m_wen));
    chk("addrW", 64'(addrW), 64'(m_addr));
    chk("dataW", 64'(dataW), 64'(m_data));
    chk("stall_a", 64'(stall_a), 64'(m_wait == LIMIT));
    chk("pend_mask", 64'(pend_mask), 64'(model_pend()));
    chk("b_ready", 64'(b_ready), 64'(q.size() < DEPTH));
  endfunction

  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          av;
    logic [4:0]  aa;
    logic [31:0] ad;
    bit          bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    bit          e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    bit          e_rdy;
    bit          e_stall;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hAAAA0001, 1'b0, 5'd0, 32'h0,        32'h20, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hAAAA0001, 32'h0,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hAAAA0001, 32'h0,  1'b1, 1'b0};
    vecs[3]  = '{1'b1, 5'd7, 32'h22,   1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22,       32'h0,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h22,       32'h0,  1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h55,       1'b0, 5'd7, 32'h22,       32'h0,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h22,       32'h0,  1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd4, 32'h44,   1'b1, 5'd3, 32'hC3,       1'b1, 5'd4, 32'h44,       32'h8,  1'b1, 1'b0};
    vecs[8]  = '{1'b1, 5'd3, 32'h33,   1'b1, 5'd6, 32'h66,       1'b1, 5'd3, 32'h33,       32'h40, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h99,       1'b0, 5'd3, 32'h33,       32'h40, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h66,       32'h0,  1'b1, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    int pushed;
    int wr_idx;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_model();

    // Table: single load, same-register kill, x0 traffic, full refusal.
    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].av, vecs[v].aa, vecs[v].ad, vecs[v].bv, vecs[v].ba, vecs[v].bd);
      cycle();
      $display("vec %0d: wen=%0d addrW=%0d dataW=%0h pend=%0h rdy=%0d", v, wen, addrW, dataW, pend_mask, b_ready);
      chk($sformatf("vec%0d_wen", v), 64'(wen), 64'(vecs[v].e_wen));
      chk($sformatf("vec%0d_addrW", v), 64'(addrW), 64'(vecs[v].e_addr));
      chk($sformatf("vec%0d_dataW", v), 64'(dataW), 64'(vecs[v].e_data));
      chk($sformatf("vec%0d_pend", v), 64'(pend_mask), 64'(vecs[v].e_pend));
      chk($sformatf("vec%0d_ready", v), 64'(b_ready), 64'(vecs[v].e_rdy));
      chk($sformatf("vec%0d_stall", v), 64'(stall_a), 64'(vecs[v].e_stall));
    end

    // A burst x1..x8 with loads x9, x10 queued at the start: starvation stall.
    for (int k = 1; k <= 8; k++) begin
      drive(1, 5'(k), 32'h100 + 32'(k), (k <= 2), (k == 1) ? 5'd9 : 5'd10, (k == 1) ? 32'h9009 : 32'h1010);
      cycle();
      $display("burst %0d: addrW=%0d stall_a=%0d b_ready=%0d", k, addrW, stall_a, b_ready);
      chk("burst_addrW", 64'(addrW), 64'(k));
      chk("burst_stall", 64'(stall_a), 64'(k >= 5));
      chk("burst_ready", 64'(b_ready), 64'(k < 2));
    end
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    $display("drain 1: wen=%0d addrW=%0d dataW=%0h stall_a=%0d", wen, addrW, dataW, stall_a);
    chk("drain1_addrW", 64'(addrW), 64'd9);
    chk("drain1_stall", 64'(stall_a), 64'd0);
    cycle();
    $display("drain 2: wen=%0d addrW=%0d dataW=%0h", wen, addrW, dataW);
    chk("drain2_addrW", 64'(addrW), 64'd10);
    chk("drain2_dataW", 64'(dataW), 64'h1010);

    // Random traffic with a narrow address range to force collisions.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0 ? (c % 64 < 40) : 1'b0, 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      cycle();
    end
    $display("random phase done: %0d checks so far", n_checks);

    // Asynchronous reset with two queued loads.
    drive(1, 5'd1, 32'h11, 1, 5'd12, 32'hC12);
    cycle();
    drive(1, 5'd2, 32'h22, 1, 5'd13, 32'hC13);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: wen=%0d stall_a=%0d pend=%0h b_ready=%0d", wen, stall_a, pend_mask, b_ready);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_stall", 64'(stall_a), 64'd0);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    chk("rst_ready", 64'(b_ready), 64'd1);
    chk("rst_addrW", 64'(addrW), 64'd0);
    chk("rst_dataW", 64'(dataW), 64'd0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) cycle();

    // Keep the FIFO saturated for 20 loads; pointers wrap several times.
    pushed = 0;
    wr_idx = 0;
    for (int c = 0; c < 200 && wr_idx < 20; c++) begin
      if (pushed < 20)
        drive(c < 2, 5'd31, 32'hF00, 1, 5'(1 + pushed % 30), 32'hD000 + 32'(pushed));
      else
        drive(0, 0, 0, 0, 0, 0);
      if (pushed < 20 && q.size() < DEPTH) pushed++;
      cycle();
      if (c >= 2 && wen) begin
        $display("wrap write %0d: addrW=%0d dataW=%0h", wr_idx, addrW, dataW);
        chk("wrap_data", 64'(dataW), 64'(32'hD000 + 32'(wr_idx)));
        chk("wrap_addr", 64'(addrW), 64'(1 + wr_idx % 30));
        wr_idx++;
      end
    end
    chk("wrap_count", 64'(wr_idx), 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
